// File: rtl/div4_seq_ctrl_if.sv
// div4_seq_ctrl_if -- request/result bundle for the 4-bit sequential divider.
//
// Signals:
//   start      request a division (master -> slave)
//   a, b       4-bit unsigned dividend / divisor (master -> slave)
//   abort      cancel an in-flight division (master -> slave, only when
//              DIV4_ABORT_EN is defined)
//   quotient   registered 4-bit quotient (slave -> master)
//   remainder  registered 4-bit remainder (slave -> master)
//   busy       divider is iterating (slave -> master)
//   done       result valid strobe (slave -> master)
//   div_zero   last accepted operation had b == 0 (slave -> master)
//
// Modports: master = operand/switch side, slave = divider.
// Optional macro: DIV4_ABORT_EN adds the abort signal.
interface div4_seq_ctrl_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;
`ifdef DIV4_ABORT_EN
  logic       abort;

  modport master (
    output start, a, b, abort,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, a, b, abort,
    output quotient, remainder, busy, done, div_zero
  );
`else
  modport master (
    output start, a, b,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, a, b,
    output quotient, remainder, busy, done, div_zero
  );
`endif
endinterface

// File: rtl/div4_seq_ctrl.sv
// div4_seq_ctrl -- sequential 4-bit unsigned restoring divider, A / B.
//
// One 4-bit two's-complement subtractor is reused over four iterations,
// producing one quotient bit per clock. A start/busy/done handshake is used;
// a zero divisor completes in a single edge with quotient=4'hF,
// remainder=a and div_zero=1.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   div4_seq_ctrl_if.slave: start, a, b, [abort] in;
//         quotient, remainder, busy, done, div_zero out
//
// Parameters:
//   DONE_HOLD  0: done is a one-cycle pulse
//              1: done stays high until the next accepted start
//
// Optional macro: DIV4_ABORT_EN enables the abort input; an abort during
// RUN returns to IDLE without touching the previous result.
module div4_seq_ctrl #(
  parameter bit DONE_HOLD = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  div4_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] bq_q, bq_d;
  logic [3:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       div_zero_q, div_zero_d;

  logic       busy_o;
  logic       done_o;
  logic       accept;
  logic       abort_w;

`ifdef DIV4_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Start is honoured everywhere except RUN, so DONE -> RUN is back-to-back.
  assign accept = bus.start && (state_q != S_RUN);

  // ------------------------------------------------------------------
  // Shared subtract datapath: t - bq as t + ~bq + 1 on a ripple-carry
  // adder. carry[4] = 1 means no borrow (t >= bq).
  // ------------------------------------------------------------------
  logic [3:0] t;
  logic       m;
  logic [3:0] bq_n;
  logic [3:0] diff;
  logic [4:0] carry;
  logic       take;
  logic [3:0] rem_iter;
  logic [3:0] quo_iter;

  assign t        = {rem_q[2:0], quo_q[3]};
  assign m        = rem_q[3];
  assign bq_n     = ~bq_q;
  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_add
    assign diff[gi]    = t[gi] ^ bq_n[gi] ^ carry[gi];
    assign carry[gi+1] = (t[gi] & bq_n[gi]) | (carry[gi] & (t[gi] ^ bq_n[gi]));
  end

  // m is the fifth bit of the shifted partial remainder; when set the value
  // is >= 16 > bq, so the subtraction always succeeds and diff is exact.
  assign take     = m | carry[4];
  assign rem_iter = take ? diff : t;
  assign quo_iter = {quo_q[2:0], take};

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      rem_q       <= 4'd0;
      quo_q       <= 4'd0;
      bq_q        <= 4'd0;
      quotient_q  <= 4'd0;
      remainder_q <= 4'd0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      bq_q        <= bq_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and datapath update
  // ------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    bq_d        = bq_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (bus.b == 4'd0) begin
            // Divide-by-zero bypasses the datapath entirely.
            state_d     = S_DONE;
            quotient_d  = 4'hF;
            remainder_d = bus.a;
            div_zero_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = 4'd0;
            quo_d   = bus.a;
            bq_d    = bus.b;
            cnt_d   = 2'd0;
          end
        end else if (state_q == S_DONE && !DONE_HOLD) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (abort_w) begin
          // Abort wins over completion; previous result is left intact.
          state_d = S_IDLE;
        end else begin
          rem_d = rem_iter;
          quo_d = quo_iter;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            quotient_d  = quo_iter;
            remainder_d = rem_iter;
            div_zero_d  = 1'b0;
            state_d     = S_DONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs: busy/done decode straight from state, so they can never
  // overlap and both read 0 during reset.
  // ------------------------------------------------------------------
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_RUN:   busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_div4_seq_ctrl.sv
// tb_div4_seq_ctrl -- directed, table-driven bench for div4_seq_ctrl
// (DONE_HOLD = 0). Abort sequence is included when DIV4_ABORT_EN is defined.
module tb_div4_seq_ctrl;

  logic clk;
  logic rst;

  div4_seq_ctrl_if bus ();

  div4_seq_ctrl #(.DONE_HOLD(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_dz;
    int         exp_edges; // edges after the accepting edge until done seen
    int         exp_busy;  // sampled cycles with busy high
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // busy and done must never overlap (checked every cycle out of reset).
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.busy && bus.done) begin
        errors++;
        $display("FAIL busy_done_overlap at %0t", $time);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait for done after an accepting edge; returns edges waited (-1 on timeout).
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = 0;
    while (!bus.done && edges < 12) begin
      if (bus.busy) busy_cyc++;
      tick();
      edges++;
    end
    if (!bus.done) edges = -1;
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    int bc;
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    tick();                   // accepting edge E0
    bus.start = 1'b0;
    wait_done(edges, bc);
    chk("latency", edges, v.exp_edges);
    chk("busy_cycles", bc, v.exp_busy);
    chk("quotient", int'(bus.quotient), int'(v.exp_q));
    chk("remainder", int'(bus.remainder), int'(v.exp_r));
    chk("div_zero", int'(bus.div_zero), int'(v.exp_dz));
    $display("div %0d/%0d -> q=%0d r=%0d dz=%0d edges=%0d", v.a, v.b,
             bus.quotient, bus.remainder, bus.div_zero, edges);
    tick();
    chk("done_pulse", int'(bus.done), 0);
    chk("quotient_hold", int'(bus.quotient), int'(v.exp_q));
  endtask

  initial begin
    int edges;
    int bc;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 4'd0;
    bus.b     = 4'd0;
`ifdef DIV4_ABORT_EN
    bus.abort = 1'b0;
`endif

    vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1,  1'b0, 4, 4};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 4, 4};
    vecs[2] = '{4'd7,  4'd9,  4'd0,  4'd7,  1'b0, 4, 4};
    vecs[3] = '{4'd14, 4'd15, 4'd0,  4'd14, 1'b0, 4, 4};
    vecs[4] = '{4'd9,  4'd0,  4'hF,  4'd9,  1'b1, 0, 0};
    vecs[5] = '{4'd15, 4'd9,  4'd1,  4'd6,  1'b0, 4, 4};
    vecs[6] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0, 4, 4};
    vecs[7] = '{4'd11, 4'd0,  4'hF,  4'd11, 1'b1, 0, 0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quotient", int'(bus.quotient), 0);
    chk("rst_remainder", int'(bus.remainder), 0);
    chk("rst_div_zero", int'(bus.div_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Start during RUN is ignored: 13/4 still yields 3/1 on schedule.
    bus.start = 1'b1; bus.a = 4'd13; bus.b = 4'd4;
    tick();                                 // E0
    bus.start = 1'b0;
    tick();                                 // E1
    bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1;
    tick();                                 // E2 (start must be ignored)
    bus.start = 1'b0;
    chk("ign_busy", int'(bus.busy), 1);
    wait_done(edges, bc);
    chk("ign_latency", edges, 2);
    chk("ign_quotient", int'(bus.quotient), 3);
    chk("ign_remainder", int'(bus.remainder), 1);
    $display("ignored-start run -> q=%0d r=%0d", bus.quotient, bus.remainder);
    tick();

    // Reset mid-run clears everything immediately.
    bus.start = 1'b1; bus.a = 4'd13; bus.b = 4'd4;
    tick();                                 // E0
    bus.start = 1'b0;
    tick();                                 // E1
    rst = 1'b1;
    #1;
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_done", int'(bus.done), 0);
    chk("mrst_quotient", int'(bus.quotient), 0);
    chk("mrst_remainder", int'(bus.remainder), 0);
    chk("mrst_div_zero", int'(bus.div_zero), 0);
    $display("reset mid-run -> q=%0d r=%0d busy=%0d", bus.quotient, bus.remainder, bus.busy);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd10; bus.b = 4'd3;
    tick();
    bus.start = 1'b0;
    wait_done(edges, bc);
    chk("post_rst_latency", edges, 4);
    chk("post_rst_quotient", int'(bus.quotient), 3);
    chk("post_rst_remainder", int'(bus.remainder), 1);
    $display("div 10/3 after reset -> q=%0d r=%0d", bus.quotient, bus.remainder);
    tick();

    // Start held high: completions every 5 edges.
    bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd5;
    tick();                                 // E0
    wait_done(edges, bc);
    chk("b2b_first_latency", edges, 4);
    chk("b2b_first_quotient", int'(bus.quotient), 2);
    chk("b2b_first_remainder", int'(bus.remainder), 2);
    tick();                                 // E5 re-accepts
    chk("b2b_restart_busy", int'(bus.busy), 1);
    wait_done(edges, bc);
    chk("b2b_second_gap", edges + 1, 5);
    chk("b2b_second_quotient", int'(bus.quotient), 2);
    chk("b2b_second_remainder", int'(bus.remainder), 2);
    $display("back-to-back 12/5 -> q=%0d r=%0d gap=%0d", bus.quotient, bus.remainder, edges + 1);
    bus.start = 1'b0;
    tick();
    chk("b2b_idle_done", int'(bus.done), 0);
    chk("b2b_idle_busy", int'(bus.busy), 0);

`ifdef DIV4_ABORT_EN
    // Abort at edge 3: back to IDLE, no done, previous 2/2 result kept.
    bus.start = 1'b1; bus.a = 4'd13; bus.b = 4'd4;
    tick();                                 // E0
    bus.start = 1'b0;
    tick();                                 // E1
    tick();                                 // E2
    bus.abort = 1'b1;
    tick();                                 // E3 aborts
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    edges = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) edges++;
      tick();
    end
    chk("abort_no_done", edges, 0);
    chk("abort_quotient", int'(bus.quotient), 2);
    chk("abort_remainder", int'(bus.remainder), 2);
    $display("abort at E3 -> q=%0d r=%0d busy=%0d", bus.quotient, bus.remainder, bus.busy);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
